// File: rtl/tff_sync_reset.sv
// tff_sync_reset: T flip-flop with asynchronous active-high reset and complementary outputs
module tff_sync_reset #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic syncReset,
  input  logic T,
  output logic Q,
  output logic notQ
);
  logic q_r = RESET_VALUE;
  always_ff @(posedge clk or posedge syncReset)
    q_r <= syncReset ? RESET_VALUE : q_r ^ T;
  assign Q = q_r;
  assign notQ = ~q_r;
endmodule

// File: tb/tb_tff_sync_reset.sv
// tb_tff_sync_reset: scoreboard bench for tff_sync_reset using directed vectors
module tb_tff_sync_reset;
  logic clk = 1'b0;
  logic syncReset = 1'b0;
  logic t_in = 1'b0;
  logic q;
  logic not_q;
  typedef struct {
    logic  exp;
    string name;
  } exp_t;
  exp_t sb[$];
  event chk;
  int n_chk = 0;
  int n_fail = 0;
  tff_sync_reset #(.RESET_VALUE(1'b0)) dut (
    .clk(clk),
    .syncReset(syncReset),
    .T(t_in),
    .Q(q),
    .notQ(not_q)
  );
  always #5 clk = ~clk;
  initial forever begin
    exp_t e;
    @(chk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_chk++;
      if (q !== e.exp) begin
        n_fail++;
        $display("FAIL %s: Q=%b expected %b at %0t", e.name, q, e.exp, $time);
      end
      n_chk++;
      if (not_q !== ~e.exp) begin
        n_fail++;
        $display("FAIL %s: notQ=%b expected %b at %0t", e.name, not_q, ~e.exp, $time);
      end
    end
  end
  task automatic post(input logic exp, input string name);
    sb.push_back('{exp, name});
    -> chk;
  endtask
  task automatic edge_chk(input logic exp, input string name);
    @(posedge clk);
    #1;
    post(exp, name);
  endtask
  initial begin
    logic tog_exp[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    #1;
    post(1'b0, "powerup_t0");
    for (int i = 0; i < 3; i++) edge_chk(1'b0, "powerup_edge");
    @(negedge clk);
    t_in = 1'b1;
    for (int i = 0; i < 4; i++) edge_chk(tog_exp[i], "toggle_run");
    edge_chk(1'b1, "hold_setup");
    @(negedge clk);
    t_in = 1'b0;
    for (int i = 0; i < 5; i++) edge_chk(1'b1, "hold");
    @(posedge clk);
    #2;
    syncReset = 1'b1;
    #1;
    post(1'b0, "async_reset_immediate");
    @(negedge clk);
    t_in = 1'b1;
    for (int i = 0; i < 10; i++) edge_chk(1'b0, "reset_beats_toggle");
    @(negedge clk);
    #2;
    syncReset = 1'b0;
    #1;
    post(1'b0, "release_no_change");
    edge_chk(1'b1, "release_first_edge");
    edge_chk(1'b0, "release_second_edge");
    @(negedge clk);
    t_in = 1'b0;
    edge_chk(1'b0, "glitch_pre");
    #1;
    t_in = 1'b1;
    #4;
    t_in = 1'b0;
    edge_chk(1'b0, "glitch_ignored");
    @(negedge clk);
    t_in = 1'b1;
    edge_chk(1'b1, "post_glitch_toggle");
    for (int i = 0; i < 20 && sb.size() != 0; i++) #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
